// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between the fetch
// requester (port I) and the load/store requester (port D).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_req_valid/ready/addr    fetch request handshake (ready is combinational)
//   i_rsp_valid/data/err      fetch response, one cycle after the grant
//   d_req_valid/ready/addr    load/store request handshake (ready is combinational)
//   d_req_we/wdata            store enable and store data
//   d_rsp_valid/data/err      load/store response, one cycle after the grant
//   mem_addr/we/wdata         memory drive (word index, write strobe, data)
//   mem_rdata                 combinational memory read data for mem_addr
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req_valid,
  output logic                     i_req_ready,
  input  logic [ADDR_W-1:0]        i_req_addr,
  output logic                     i_rsp_valid,
  output logic [DATA_W-1:0]        i_rsp_data,
  output logic                     i_rsp_err,
  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic [ADDR_W-1:0]        d_req_addr,
  input  logic                     d_req_we,
  input  logic [DATA_W-1:0]        d_req_wdata,
  output logic                     d_rsp_valid,
  output logic [DATA_W-1:0]        d_rsp_data,
  output logic                     d_rsp_err,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = 4;

  logic          i_err, d_err;
  logic          i_gnt, d_gnt;
  logic [SW-1:0] streak_q, streak_d;

  logic              i_rsp_valid_q, i_rsp_valid_d;
  logic [DATA_W-1:0] i_rsp_data_q,  i_rsp_data_d;
  logic              i_rsp_err_q,   i_rsp_err_d;
  logic              d_rsp_valid_q, d_rsp_valid_d;
  logic [DATA_W-1:0] d_rsp_data_q,  d_rsp_data_d;
  logic              d_rsp_err_q,   d_rsp_err_d;

  // Misaligned or beyond the last word.
  assign i_err = (i_req_addr[1:0] != 2'b00) || ((i_req_addr >> 2) >= ADDR_W'(DEPTH));
  assign d_err = (d_req_addr[1:0] != 2'b00) || ((d_req_addr >> 2) >= ADDR_W'(DEPTH));

  // D has priority unless I has been starved for MAX_STREAK D grants; nothing is granted in reset.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (!rst) begin
      if (d_req_valid && !(i_req_valid && (streak_q == SW'(MAX_STREAK)))) begin
        d_gnt = 1'b1;
      end else if (i_req_valid) begin
        i_gnt = 1'b1;
      end
    end
  end

  assign i_req_ready = i_gnt;
  assign d_req_ready = d_gnt;

  // Memory drive follows the winner; idle cycles park the address at 0.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = d_req_wdata;
    if (i_gnt) begin
      mem_addr = i_req_addr[2 +: AW];
    end else if (d_gnt) begin
      mem_addr = d_req_addr[2 +: AW];
      mem_we   = d_req_we && !d_err;
    end
  end

  // Next-state: starvation counter and per-port response registers.
  always_comb begin
    streak_d      = streak_q;
    i_rsp_valid_d = i_gnt;
    i_rsp_data_d  = i_rsp_data_q;
    i_rsp_err_d   = i_rsp_err_q;
    d_rsp_valid_d = d_gnt;
    d_rsp_data_d  = d_rsp_data_q;
    d_rsp_err_d   = d_rsp_err_q;

    if (!i_req_valid || i_gnt) begin
      streak_d = '0;
    end else if (d_gnt && (streak_q < SW'(MAX_STREAK))) begin
      streak_d = streak_q + SW'(1);
    end

    if (i_gnt) begin
      i_rsp_err_d  = i_err;
      i_rsp_data_d = i_err ? '0 : mem_rdata;
    end
    if (d_gnt) begin
      d_rsp_err_d  = d_err;
      d_rsp_data_d = (d_err || d_req_we) ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q      <= '0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= '0;
      i_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
      d_rsp_err_q   <= 1'b0;
    end else begin
      streak_q      <= streak_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      i_rsp_err_q   <= i_rsp_err_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_data_q  <= d_rsp_data_d;
      d_rsp_err_q   <= d_rsp_err_d;
    end
  end

  // A response due while reset is asserted is suppressed.
  assign i_rsp_valid = i_rsp_valid_q && !rst;
  assign d_rsp_valid = d_rsp_valid_q && !rst;
  assign i_rsp_data  = i_rsp_data_q;
  assign i_rsp_err   = i_rsp_err_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign d_rsp_err   = d_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 16-word memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we;
  logic [31:0] d_req_addr, d_req_wdata;
  logic        d_rsp_valid, d_rsp_err;
  logic [31:0] d_rsp_data;
  logic [3:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Combinational-read, clocked-write memory.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    // 1. Reset held two cycles with both requesters active.
    rst = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h0;
    d_req_valid = 1'b1; d_req_addr = 32'h0; d_req_we = 1'b1; d_req_wdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_i_ready", 32'(i_req_ready), 32'd0);
      chk("rst_d_ready", 32'(d_req_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
      chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    end
    chk("rst_i_rsp_data", i_rsp_data, 32'd0);
    chk("rst_d_rsp_err", 32'(d_rsp_err), 32'd0);

    // Release; preload mem[2] with a store through D.
    rst = 1'b0;
    i_req_valid = 1'b0;
    d_req_addr = 32'h8; d_req_wdata = 32'hDEAD_BEEF;
    settle();
    chk("pre_d_ready", 32'(d_req_ready), 32'd1);
    chk("pre_mem_we", 32'(mem_we), 32'd1);
    chk("pre_mem_addr", 32'(mem_addr), 32'd2);
    tick();
    chk("pre_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("pre_d_rsp_data", d_rsp_data, 32'd0);

    // 2. Single fetch of 0x8.
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h8;
    settle();
    chk("f_i_ready", 32'(i_req_ready), 32'd1);
    chk("f_mem_addr", 32'(mem_addr), 32'd2);
    chk("f_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("f_i_rsp_valid", 32'(i_rsp_valid), 32'd1);
    chk("f_i_rsp_data", i_rsp_data, 32'hDEAD_BEEF);
    chk("f_i_rsp_err", 32'(i_rsp_err), 32'd0);
    chk("f_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    i_req_valid = 1'b0;
    tick();
    chk("f_i_rsp_pulse", 32'(i_rsp_valid), 32'd0);
    chk("f_i_rsp_hold", i_rsp_data, 32'hDEAD_BEEF);

    // 3. Continuous contention: D,D,D,D,I repeated.
    i_req_valid = 1'b1; i_req_addr = 32'h8;
    d_req_valid = 1'b1; d_req_addr = 32'h8; d_req_we = 1'b0;
    settle();
    for (int k = 0; k < 10; k++) begin
      chk("arb_d_ready", 32'(d_req_ready), 32'((k % 5) != 4));
      chk("arb_i_ready", 32'(i_req_ready), 32'((k % 5) == 4));
      tick();
      chk("arb_i_rsp_valid", 32'(i_rsp_valid), 32'((k % 5) == 4));
      chk("arb_d_rsp_valid", 32'(d_rsp_valid), 32'((k % 5) != 4));
    end
    chk("arb_i_rsp_data", i_rsp_data, 32'hDEAD_BEEF);
    chk("arb_d_rsp_data", d_rsp_data, 32'hDEAD_BEEF);

    // 4. Store 0x12345678 to 0x4, then fetch 0x4 the next cycle.
    i_req_valid = 1'b0;
    d_req_addr = 32'h4; d_req_we = 1'b1; d_req_wdata = 32'h1234_5678;
    settle();
    chk("sf_d_ready", 32'(d_req_ready), 32'd1);
    chk("sf_mem_we", 32'(mem_we), 32'd1);
    chk("sf_mem_addr", 32'(mem_addr), 32'd1);
    tick();
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h4;
    settle();
    chk("sf_i_ready", 32'(i_req_ready), 32'd1);
    chk("sf_d_rsp_data", d_rsp_data, 32'd0);
    tick();
    chk("sf_i_rsp_valid", 32'(i_rsp_valid), 32'd1);
    chk("sf_i_rsp_data", i_rsp_data, 32'h1234_5678);

    // 5. Errors: misaligned D store, out-of-range I fetch.
    i_req_valid = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h6; d_req_we = 1'b1; d_req_wdata = 32'hBAD0_BAD0;
    settle();
    chk("e_d_ready", 32'(d_req_ready), 32'd1);
    chk("e_d_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("e_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("e_d_rsp_err", 32'(d_rsp_err), 32'd1);
    chk("e_d_rsp_data", d_rsp_data, 32'd0);
    d_req_valid = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h40;
    settle();
    chk("e_i_ready", 32'(i_req_ready), 32'd1);
    chk("e_i_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("e_i_rsp_valid", 32'(i_rsp_valid), 32'd1);
    chk("e_i_rsp_err", 32'(i_rsp_err), 32'd1);
    chk("e_i_rsp_data", i_rsp_data, 32'd0);
    i_req_addr = 32'h4;
    tick();
    chk("e_unchanged_err", 32'(i_rsp_err), 32'd0);
    chk("e_unchanged_data", i_rsp_data, 32'h1234_5678);
    i_req_valid = 1'b0;
    tick();

    // 6. Reset right after a D load grant, with I waiting (streak reaches 3).
    i_req_valid = 1'b1; i_req_addr = 32'h8;
    d_req_valid = 1'b1; d_req_addr = 32'h8; d_req_we = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk("mr_pre_d_ready", 32'(d_req_ready), 32'd1);
      tick();
    end
    rst = 1'b1;
    settle();
    chk("mr_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("mr_d_ready", 32'(d_req_ready), 32'd0);
    chk("mr_i_ready", 32'(i_req_ready), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("mr_post_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    // Streak restarts at 0, so four D grants precede the I grant.
    for (int k = 0; k < 5; k++) begin
      chk("mr_arb_d_ready", 32'(d_req_ready), 32'(k != 4));
      chk("mr_arb_i_ready", 32'(i_req_ready), 32'(k == 4));
      tick();
    end
    d_req_valid = 1'b0;
    settle();
    chk("mr_idle_i_ready", 32'(i_req_ready), 32'd1);
    tick();
    chk("mr_idle_i_rsp_valid", 32'(i_rsp_valid), 32'd1);
    chk("mr_idle_i_rsp_data", i_rsp_data, 32'hDEAD_BEEF);
    i_req_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
